rv_csr_trap_seq: RTL and testbench

Trap sequencer for the machine-level CSR file. It arbitrates between synchronous exceptions (ebreak, ecall, illegal instruction), `mret` and pending interrupts (timer, external). It then walks the core through a fixed flush / save / redirect sequence that drives `mepc`, `mcause` and `mstatus` updates in `rv_csr_machine` and the PC-load port of fetch. It sits beside `rv_csr` and replaces the direct ebreak-to-trap path.

---
 rtl/rv_csr_pkg.sv | 42 ++++
 rtl/rv_csr_trap_prio.sv | 56 +++++
 rtl/rv_csr_trap_seq.sv | 164 ++++++++++++++++
 tb/tb_rv_csr_trap_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_csr_pkg.sv
// rv_csr_pkg
//   Shared definitions for the machine-level CSR trap path: the trap
//   sequencer state and kind enums, mcause codes, mtvec mode encoding and
//   the trap-target helper used by the sequencer.
package rv_csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_SAVE  = 3'd2,
    ST_RET   = 3'd3,
    ST_JUMP  = 3'd4
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } trap_kind_e;

  localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK    = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_INT_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_INT_EXT   = 32'h8000_000B;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Trap target expressed in halfword-address form (bits [31:1]).
  // In that form the vectored offset 4*code becomes 2*code. Only mode 01
  // vectors, and only interrupts; modes 10/11 fall back to direct.
  function automatic logic [31:1] trap_target(input logic [31:0] mtvec,
                                              input logic        is_int,
                                              input logic [4:0]  code);
    logic [31:1] base;
    base = {mtvec[31:2], 1'b0};
    if (is_int && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
      return base + {25'd0, code, 1'b0};
    end
    return base;
  endfunction

endpackage

// File: rtl/rv_csr_trap_prio.sv
// rv_csr_trap_prio
//   Combinational priority encoder for trap/return requests.
//   Order: illegal > ecall > ebreak > mret > external irq > timer irq.
//   Interrupts need the global MIE and their own enable bit.
// Ports:
//   i_illegal, i_ecall, i_ebreak, i_mret : event strobes
//   i_int_timer, i_int_ext               : pending interrupt levels
//   i_mstatus_mie, i_mie_mtie, i_mie_meie: enables
//   o_take  : some request wins this cycle
//   o_kind  : trap or return
//   o_cause : mcause value of the winner (0 for mret)
module rv_csr_trap_prio
  import rv_csr_pkg::*;
(
  input  logic        i_illegal,
  input  logic        i_ecall,
  input  logic        i_ebreak,
  input  logic        i_mret,
  input  logic        i_int_timer,
  input  logic        i_int_ext,
  input  logic        i_mstatus_mie,
  input  logic        i_mie_mtie,
  input  logic        i_mie_meie,
  output logic        o_take,
  output trap_kind_e  o_kind,
  output logic [31:0] o_cause
);

  logic ext_ok;
  logic timer_ok;

  assign ext_ok   = i_mstatus_mie & i_mie_meie & i_int_ext;
  assign timer_ok = i_mstatus_mie & i_mie_mtie & i_int_timer;

  always_comb begin
    o_take  = 1'b1;
    o_kind  = KIND_TRAP;
    o_cause = '0;
    if (i_illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (i_ecall) begin
      o_cause = CAUSE_ECALL_M;
    end else if (i_ebreak) begin
      o_cause = CAUSE_EBREAK;
    end else if (i_mret) begin
      o_kind = KIND_RET;
    end else if (ext_ok) begin
      o_cause = CAUSE_INT_EXT;
    end else if (timer_ok) begin
      o_cause = CAUSE_INT_TIMER;
    end else begin
      o_take = 1'b0;
    end
  end

endmodule

// File: rtl/rv_csr_trap_seq.sv
// rv_csr_trap_seq
//   Machine-mode trap sequencer. Accepts one exception, mret or enabled
//   interrupt while idle, drains the pipeline, performs the CSR update
//   (trap save or mret restore) and redirects fetch.
// Ports:
//   i_clk, i_reset_n          : clock, async active-low reset
//   i_ebreak/ecall/illegal/mret : execute-stage strobes
//   i_int_timer, i_int_ext    : pending interrupt levels
//   i_mstatus_mie, i_mie_*    : interrupt enables
//   i_pc, i_pc_next, i_mepc   : PCs, bits [IADDR_SPACE_BITS-1:1]
//   i_mtvec                   : mtvec CSR
//   i_pipe_empty              : pipeline drained
//   o_busy, o_flush           : sequence active / front-end kill
//   o_mepc_we/o_mepc, o_mcause_we/o_mcause : CSR writes
//   o_mstatus_trap/o_mstatus_ret : mstatus stack push / pop
//   o_pc_load/o_pc_target     : fetch redirect
//
// state  | meaning
// IDLE   | waiting; events and interrupts are evaluated here only
// FLUSH  | front end killed, waiting for drain or FLUSH_MAX timeout
// SAVE   | write mepc/mcause, push mstatus (trap)
// RET    | pop mstatus, sample mepc as target (mret)
// JUMP   | one-cycle fetch redirect
module rv_csr_trap_seq
  import rv_csr_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int FLUSH_MAX        = 15
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_ebreak,
  input  logic                          i_ecall,
  input  logic                          i_illegal,
  input  logic                          i_mret,
  input  logic                          i_int_timer,
  input  logic                          i_int_ext,
  input  logic                          i_mstatus_mie,
  input  logic                          i_mie_mtie,
  input  logic                          i_mie_meie,
  input  logic [IADDR_SPACE_BITS-1:1]   i_pc,
  input  logic [IADDR_SPACE_BITS-1:1]   i_pc_next,
  input  logic [31:0]                   i_mtvec,
  input  logic [IADDR_SPACE_BITS-1:1]   i_mepc,
  input  logic                          i_pipe_empty,
  output logic                          o_busy,
  output logic                          o_flush,
  output logic                          o_mepc_we,
  output logic [IADDR_SPACE_BITS-1:1]   o_mepc,
  output logic                          o_mcause_we,
  output logic [31:0]                   o_mcause,
  output logic                          o_mstatus_trap,
  output logic                          o_mstatus_ret,
  output logic                          o_pc_load,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc_target
);

  localparam logic [7:0] FLUSH_CNT_MAX = 8'(FLUSH_MAX);

  trap_state_e                 state_q, state_d;
  logic [7:0]                  flush_cnt_q, flush_cnt_d;
  trap_kind_e                  kind_q, kind_d;
  logic [31:0]                 cause_q, cause_d;
  logic [IADDR_SPACE_BITS-1:1] epc_q, epc_d;
  logic [IADDR_SPACE_BITS-1:1] target_q, target_d;

  logic        prio_take;
  trap_kind_e  prio_kind;
  logic [31:0] prio_cause;
  logic [31:1] trap_tgt;

  rv_csr_trap_prio u_prio (
    .i_illegal     (i_illegal),
    .i_ecall       (i_ecall),
    .i_ebreak      (i_ebreak),
    .i_mret        (i_mret),
    .i_int_timer   (i_int_timer),
    .i_int_ext     (i_int_ext),
    .i_mstatus_mie (i_mstatus_mie),
    .i_mie_mtie    (i_mie_mtie),
    .i_mie_meie    (i_mie_meie),
    .o_take        (prio_take),
    .o_kind        (prio_kind),
    .o_cause       (prio_cause)
  );

  // mtvec is sampled in SAVE so a late CSR write still lands.
  assign trap_tgt = trap_target(i_mtvec, cause_q[31], cause_q[4:0]);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    kind_d      = kind_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    target_d    = target_q;
    case (state_q)
      ST_IDLE: begin
        flush_cnt_d = '0;
        if (prio_take) begin
          state_d = ST_FLUSH;
          kind_d  = prio_kind;
          cause_d = prio_cause;
          // Interrupts resume at the next instruction, exceptions re-run it.
          epc_d   = prio_cause[31] ? i_pc_next : i_pc;
        end
      end
      ST_FLUSH: begin
        if (i_pipe_empty || (flush_cnt_q == FLUSH_CNT_MAX)) begin
          state_d     = (kind_q == KIND_RET) ? ST_RET : ST_SAVE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      ST_SAVE: begin
        target_d = trap_tgt[IADDR_SPACE_BITS-1:1];
        state_d  = ST_JUMP;
      end
      ST_RET: begin
        target_d = i_mepc;
        state_d  = ST_JUMP;
      end
      ST_JUMP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      kind_q      <= KIND_TRAP;
      cause_q     <= '0;
      epc_q       <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      kind_q      <= kind_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      target_q    <= target_d;
    end
  end

  // Outputs decode registered state only; data buses are zeroed outside
  // their strobe so a stale capture never leaks.
  assign o_busy         = (state_q != ST_IDLE);
  assign o_flush        = (state_q != ST_IDLE);
  assign o_mepc_we      = (state_q == ST_SAVE);
  assign o_mcause_we    = (state_q == ST_SAVE);
  assign o_mstatus_trap = (state_q == ST_SAVE);
  assign o_mstatus_ret  = (state_q == ST_RET);
  assign o_pc_load      = (state_q == ST_JUMP);
  assign o_mepc         = (state_q == ST_SAVE) ? epc_q : '0;
  assign o_mcause       = (state_q == ST_SAVE) ? cause_q : '0;
  assign o_pc_target    = (state_q == ST_JUMP) ? target_q : '0;

endmodule

// File: tb/tb_rv_csr_trap_seq.sv
module tb_rv_csr_trap_seq;

  localparam int IAB  = 32;
  localparam int FMAX = 15;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_ebreak, i_ecall, i_illegal, i_mret;
  logic          i_int_timer, i_int_ext;
  logic          i_mstatus_mie, i_mie_mtie, i_mie_meie;
  logic [IAB-1:1] i_pc, i_pc_next, i_mepc;
  logic [31:0]   i_mtvec;
  logic          i_pipe_empty;
  logic          o_busy, o_flush, o_mepc_we, o_mcause_we;
  logic          o_mstatus_trap, o_mstatus_ret, o_pc_load;
  logic [IAB-1:1] o_mepc, o_pc_target;
  logic [31:0]   o_mcause;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        ebreak, ecall, illegal, mret;
    logic        int_timer, int_ext;
    logic        mie, mtie, meie;
    logic [31:0] pc, pc_next, mepc, mtvec;   // byte addresses
  } ev_t;

  rv_csr_trap_seq #(.IADDR_SPACE_BITS(IAB), .FLUSH_MAX(FMAX)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_ebreak(i_ebreak), .i_ecall(i_ecall), .i_illegal(i_illegal), .i_mret(i_mret),
    .i_int_timer(i_int_timer), .i_int_ext(i_int_ext),
    .i_mstatus_mie(i_mstatus_mie), .i_mie_mtie(i_mie_mtie), .i_mie_meie(i_mie_meie),
    .i_pc(i_pc), .i_pc_next(i_pc_next), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .i_pipe_empty(i_pipe_empty),
    .o_busy(o_busy), .o_flush(o_flush), .o_mepc_we(o_mepc_we), .o_mepc(o_mepc),
    .o_mcause_we(o_mcause_we), .o_mcause(o_mcause),
    .o_mstatus_trap(o_mstatus_trap), .o_mstatus_ret(o_mstatus_ret),
    .o_pc_load(o_pc_load), .o_pc_target(o_pc_target)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // {busy, flush, mepc_we, mcause_we, mstatus_trap, mstatus_ret, pc_load}
  function automatic logic [31:0] ctl();
    return {25'd0, o_busy, o_flush, o_mepc_we, o_mcause_we,
            o_mstatus_trap, o_mstatus_ret, o_pc_load};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_events();
    i_ebreak = 0; i_ecall = 0; i_illegal = 0; i_mret = 0;
    i_int_timer = 0; i_int_ext = 0;
  endtask

  task automatic noise_events();
    i_ebreak    = 1'($urandom);
    i_ecall     = 1'($urandom);
    i_illegal   = 1'($urandom);
    i_mret      = 1'($urandom);
    i_int_timer = 1'($urandom);
    i_int_ext   = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/ctl"}, ctl(), 32'd0);
    chk({tag, "/mepc"}, {1'b0, o_mepc}, 32'd0);
    chk({tag, "/mcause"}, o_mcause, 32'd0);
    chk({tag, "/target"}, {1'b0, o_pc_target}, 32'd0);
  endtask

  // Reference: what the sequencer should do with this request, in byte addresses.
  function automatic void model(input ev_t e, output bit take, output bit is_ret,
                                output logic [31:0] cause, output logic [31:0] epc,
                                output logic [31:0] tgt);
    bit is_int;
    take = 1; is_ret = 0; cause = 0;
    if (e.illegal)                         cause = 32'h2;
    else if (e.ecall)                      cause = 32'hB;
    else if (e.ebreak)                     cause = 32'h3;
    else if (e.mret)                       is_ret = 1;
    else if (e.mie && e.meie && e.int_ext)   cause = 32'h8000000B;
    else if (e.mie && e.mtie && e.int_timer) cause = 32'h80000007;
    else                                   take = 0;
    is_int = (cause >= 32'h80000000);
    epc = is_int ? e.pc_next : e.pc;
    if (is_ret)
      tgt = e.mepc;
    else if (is_int && (e.mtvec % 4 == 1))
      tgt = (e.mtvec - (e.mtvec % 4)) + 4 * (cause % 32);
    else
      tgt = e.mtvec - (e.mtvec % 4);
  endfunction

  // Called in an IDLE cycle; leaves the bench in an IDLE cycle.
  // empty_at: flush-cycle index where i_pipe_empty first rises (held after).
  task automatic run_event(input string name, input ev_t e, input int empty_at);
    bit take, is_ret;
    logic [31:0] cause, epc, tgt;
    int n_flush;
    model(e, take, is_ret, cause, epc, tgt);
    i_ebreak = e.ebreak; i_ecall = e.ecall; i_illegal = e.illegal; i_mret = e.mret;
    i_int_timer = e.int_timer; i_int_ext = e.int_ext;
    i_mstatus_mie = e.mie; i_mie_mtie = e.mtie; i_mie_meie = e.meie;
    i_pc = e.pc[31:1]; i_pc_next = e.pc_next[31:1];
    i_mepc = e.mepc[31:1]; i_mtvec = e.mtvec;
    i_pipe_empty = 0;
    tick();
    if (!take) begin
      clear_events();
      chk({name, "/notake1"}, ctl(), 32'd0);
      tick();
      chk({name, "/notake2"}, ctl(), 32'd0);
      return;
    end
    n_flush = ((empty_at < FMAX) ? empty_at : FMAX) + 1;
    for (int k = 0; k < n_flush; k++) begin
      if (k > 0) tick();
      i_pipe_empty = (k >= empty_at);
      noise_events();
      chk({name, "/flush"}, ctl(), 32'h60);
    end
    tick();
    noise_events();
    if (is_ret) begin
      chk({name, "/ret"}, ctl(), 32'h62);
    end else begin
      chk({name, "/save"}, ctl(), 32'h7C);
      chk({name, "/mepc"}, {1'b0, o_mepc}, {1'b0, epc[31:1]});
      chk({name, "/mcause"}, o_mcause, cause);
    end
    tick();
    noise_events();
    chk({name, "/jump"}, ctl(), 32'h61);
    chk({name, "/target"}, {1'b0, o_pc_target}, {1'b0, tgt[31:1]});
    tick();
    clear_events();
    i_pipe_empty = 0;
    chk({name, "/idle"}, ctl(), 32'd0);
    tick();
    chk({name, "/idle2"}, ctl(), 32'd0);
  endtask

  initial begin
    ev_t e;
    i_reset_n = 0;
    clear_events();
    i_mstatus_mie = 0; i_mie_mtie = 0; i_mie_meie = 0;
    i_pc = '0; i_pc_next = '0; i_mepc = '0; i_mtvec = '0; i_pipe_empty = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_reset_n = 1;
    tick();
    chk_all_zero("post_reset");

    e = '{default: '0};
    e.ebreak = 1; e.pc = 32'h100; e.mtvec = 32'h400;
    run_event("ebreak", e, 0);

    e = '{default: '0};
    e.int_timer = 1; e.mie = 1; e.mtie = 1; e.pc = 32'h204; e.pc_next = 32'h208;
    e.mtvec = 32'h801;
    run_event("timer_vec", e, 0);

    e = '{default: '0};
    e.ecall = 1; e.ebreak = 1; e.pc = 32'h40; e.mtvec = 32'h400;
    run_event("ecall_ebreak", e, 0);

    e = '{default: '0};
    e.mret = 1; e.mepc = 32'h300; e.mtvec = 32'h400;
    run_event("mret_timeout", e, 20);

    e = '{default: '0};
    e.illegal = 1; e.mret = 1; e.int_ext = 1; e.mie = 1; e.meie = 1;
    e.pc = 32'h1234; e.pc_next = 32'h1238; e.mtvec = 32'h2001;
    run_event("illegal_prio", e, 3);

    e = '{default: '0};
    e.int_ext = 1; e.int_timer = 1; e.mie = 1; e.meie = 1; e.mtie = 1;
    e.pc_next = 32'h500; e.mtvec = 32'h1001;
    run_event("ext_vec", e, 15);

    e = '{default: '0};
    e.int_timer = 1; e.mtie = 1; e.mie = 0; e.pc_next = 32'h600; e.mtvec = 32'h800;
    run_event("timer_mie0", e, 0);
    e.mie = 1;
    run_event("timer_mie1", e, 14);

    e = '{default: '0};
    e.int_timer = 1; e.mie = 1; e.mtie = 0; e.mtvec = 32'h800;
    run_event("timer_mtie0", e, 0);

    e = '{default: '0};
    e.int_timer = 1; e.mie = 1; e.mtie = 1; e.pc_next = 32'h10; e.mtvec = 32'hFFFF_FFF1;
    run_event("vec_wrap", e, 1);

    e = '{default: '0};
    e.int_timer = 1; e.mie = 1; e.mtie = 1; e.pc_next = 32'h20; e.mtvec = 32'h802;
    run_event("mode10_direct", e, 2);

    // Reset in the middle of FLUSH.
    e = '{default: '0};
    i_ebreak = 1; i_pc = 31'h80; i_mtvec = 32'h400; i_pipe_empty = 0;
    tick();
    clear_events();
    chk("rst_pre/ctl", ctl(), 32'h60);
    tick();
    #2;
    i_reset_n = 0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge i_clk);
    i_reset_n = 1;
    i_pipe_empty = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_after/ctl", ctl(), 32'd0);
    end
    i_pipe_empty = 0;

    for (int n = 0; n < 40; n++) begin
      e.ebreak    = ($urandom_range(0, 3) == 0);
      e.ecall     = ($urandom_range(0, 3) == 0);
      e.illegal   = ($urandom_range(0, 4) == 0);
      e.mret      = ($urandom_range(0, 3) == 0);
      e.int_timer = 1'($urandom);
      e.int_ext   = 1'($urandom);
      e.mie       = 1'($urandom);
      e.mtie      = 1'($urandom);
      e.meie      = 1'($urandom);
      e.pc        = $urandom & 32'hFFFF_FFFE;
      e.pc_next   = $urandom & 32'hFFFF_FFFE;
      e.mepc      = $urandom & 32'hFFFF_FFFE;
      e.mtvec     = $urandom;
      run_event("random", e, $urandom_range(0, 20));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
